// File: rtl/mine_placer.sv
// Mine layout generator: places a fixed number of mines on the selected board
// using a free-running Galois LFSR, keeping the player's first-click cell clear.
module mine_placer #(
    parameter int unsigned EASY_MINES   = 10,
    parameter int unsigned MEDIUM_MINES = 16,
    parameter int unsigned HARD_MINES   = 40,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] level,
    input  logic [4:0] safe_x,
    input  logic [4:0] safe_y,
    output logic       busy,
    output logic       done,
    output logic [5:0] mines_placed,
    output logic       array_easy_out   [7:0][7:0],
    output logic       array_medium_out [9:0][9:0],
    output logic       array_hard_out   [15:0][15:0]
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] POLY = 16'hB400;

    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

    state_t      state_q;
    logic [15:0] lfsr_q, lfsr_d;
    logic [1:0]  level_q;
    logic [4:0]  sx_q, sy_q;
    logic [5:0]  target_q;
    logic [5:0]  cnt_q, cnt_d;
    logic        busy_q, done_q;
    logic        easy_q [7:0][7:0];
    logic        med_q  [9:0][9:0];
    logic        hard_q [15:0][15:0];

    logic [3:0]  cx, cy;
    logic [4:0]  n;
    logic        in_range, occupied, is_safe, accept;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? POLY : 16'h0000);
        cx     = lfsr_q[3:0];
        cy     = lfsr_q[11:8];
        cnt_d  = cnt_q + 6'd1;
        case (level_q)
            2'd3:    n = 5'd16;
            2'd2:    n = 5'd10;
            default: n = 5'd8;
        endcase
        in_range = ({1'b0, cx} < n) && ({1'b0, cy} < n);
        // Occupancy is only looked up for on-board cells so the smaller maps are never over-indexed.
        occupied = 1'b0;
        if (in_range) begin
            case (level_q)
                2'd3:    occupied = hard_q[cy][cx];
                2'd2:    occupied = med_q[cy][cx];
                default: occupied = easy_q[cy[2:0]][cx[2:0]];
            endcase
        end
        is_safe = ({1'b0, cx} == sx_q) && ({1'b0, cy} == sy_q);
        accept  = in_range && !occupied && !is_safe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED;
            level_q  <= 2'd0;
            sx_q     <= 5'd0;
            sy_q     <= 5'd0;
            target_q <= 6'd0;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            easy_q   <= '{default: 1'b0};
            med_q    <= '{default: 1'b0};
            hard_q   <= '{default: 1'b0};
        end else begin
            lfsr_q <= lfsr_d;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        level_q <= level;
                        sx_q    <= safe_x;
                        sy_q    <= safe_y;
                        case (level)
                            2'd3:    target_q <= 6'(HARD_MINES);
                            2'd2:    target_q <= 6'(MEDIUM_MINES);
                            default: target_q <= 6'(EASY_MINES);
                        endcase
                        busy_q  <= 1'b1;
                        state_q <= CLEAR;
                    end
                end
                CLEAR: begin
                    easy_q  <= '{default: 1'b0};
                    med_q   <= '{default: 1'b0};
                    hard_q  <= '{default: 1'b0};
                    cnt_q   <= 6'd0;
                    state_q <= PLACE;
                end
                PLACE: begin
                    if (accept) begin
                        case (level_q)
                            2'd3:    hard_q[cy][cx] <= 1'b1;
                            2'd2:    med_q[cy][cx]  <= 1'b1;
                            default: easy_q[cy[2:0]][cx[2:0]] <= 1'b1;
                        endcase
                        cnt_q <= cnt_d;
                        if (cnt_d == target_q) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign mines_placed     = cnt_q;
    assign array_easy_out   = easy_q;
    assign array_medium_out = med_q;
    assign array_hard_out   = hard_q;

endmodule
